// File: rtl/hazard_stall_controller.sv
// Pipeline hazard detector: tracks in-flight register writers after ID and
// stalls or bubbles the ID instruction on a RAW dependency it cannot forward.
module hazard_stall_controller #(
  parameter int unsigned REG_AW    = 5,
  parameter int unsigned DEPTH     = 3,
  parameter int unsigned FWD_MODE  = 1,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_STALL = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src1,
  input  logic [REG_AW-1:0] src2,
  input  logic              use_src2,
  input  logic              is_branch,
  input  logic              wb_en,
  input  logic              is_load,
  input  logic [REG_AW-1:0] dest,
  input  logic              flush,
  output logic              stall,
  output logic              bubble,
  output logic [CNT_W-1:0]  stall_count,
  output logic              wdog_err,
  output logic [1:0]        state
);

  localparam int unsigned CONS_W = $clog2(MAX_STALL + 1);
  localparam logic [CONS_W-1:0] CONS_MAX = CONS_W'(MAX_STALL);

  typedef struct packed {
    logic              v;
    logic              wb;
    logic              ld;
    logic [REG_AW-1:0] dst;
  } entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  entry_t [DEPTH-1:0] trk_q, trk_d;
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  logic [CONS_W-1:0]  cons_q, cons_d;
  logic               wdog_q, wdog_d;

  logic [DEPTH-1:0]   match;
  logic               match1;
  logic               hz;
  logic               stall_int;

  // Hazard detection against every tracked stage.
  always_comb begin
    match  = '0;
    match1 = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      match[k] = trk_q[k].v & trk_q[k].wb & (trk_q[k].dst != '0) &
                 ((src1 == trk_q[k].dst) | (use_src2 & (src2 == trk_q[k].dst)));
      if (k == 1) match1 = match[k];
    end
  end

  // With forwarding only load-use into EXE and branch operands resolved in ID
  // (needing EXE or MEM results) still stall.
  always_comb begin
    hz = 1'b0;
    if (FWD_MODE == 0) begin
      hz = |match;
    end else begin
      hz = (match[0] & trk_q[0].ld) | (is_branch & (match[0] | match1));
    end
  end

  assign stall_int = id_valid & hz & ~flush;
  assign stall     = stall_int;
  assign bubble    = stall_int;

  // Tracker shifts every edge; a stalled or flushed slot enters as invalid.
  always_comb begin
    trk_d = trk_q;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      trk_d[k] = trk_q[k-1];
    end
    trk_d[0].v   = id_valid & ~stall_int & ~flush;
    trk_d[0].wb  = wb_en;
    trk_d[0].ld  = is_load;
    trk_d[0].dst = dest;
    if (flush) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        trk_d[k].v = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_FLUSH;
    end else begin
      case (state_q)
        ST_RUN:   if (stall_int) state_d = ST_STALL;
        ST_STALL: if (!stall_int) state_d = ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall_int && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end

    cons_d = cons_q;
    if (flush || !stall_int) begin
      cons_d = '0;
    end else if (cons_q != CONS_MAX) begin
      cons_d = cons_q + 1'b1;
    end

    // Raised on the same edge the consecutive count reaches the limit.
    wdog_d = wdog_q | (cons_d == CONS_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trk_q         <= '0;
      state_q       <= ST_RUN;
      stall_count_q <= '0;
      cons_q        <= '0;
      wdog_q        <= 1'b0;
    end else begin
      trk_q         <= trk_d;
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
      cons_q        <= cons_d;
      wdog_q        <= wdog_d;
    end
  end

  assign stall_count = stall_count_q;
  assign wdog_err    = wdog_q;
  assign state       = state_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: three controller variants (no forwarding, forwarding,
// no forwarding with short watchdog and narrow counter) share one stimulus.
module tb_hazard_stall_controller;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] src1;
  logic [4:0] src2;
  logic       use_src2;
  logic       is_branch;
  logic       wb_en;
  logic       is_load;
  logic [4:0] dest;
  logic       flush;

  logic        stall0, bubble0, wdog0;
  logic [15:0] cnt0;
  logic [1:0]  state0;
  logic        stall1, bubble1, wdog1;
  logic [15:0] cnt1;
  logic [1:0]  state1;
  logic        stall2, bubble2, wdog2;
  logic [1:0]  cnt2;
  logic [1:0]  state2;

  int unsigned n_checks;
  int unsigned n_fail;

  hazard_stall_controller #(.REG_AW(5), .DEPTH(3), .FWD_MODE(0), .CNT_W(16), .MAX_STALL(8)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .use_src2(use_src2), .is_branch(is_branch), .wb_en(wb_en), .is_load(is_load),
    .dest(dest), .flush(flush), .stall(stall0), .bubble(bubble0),
    .stall_count(cnt0), .wdog_err(wdog0), .state(state0)
  );

  hazard_stall_controller #(.REG_AW(5), .DEPTH(3), .FWD_MODE(1), .CNT_W(16), .MAX_STALL(8)) dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .use_src2(use_src2), .is_branch(is_branch), .wb_en(wb_en), .is_load(is_load),
    .dest(dest), .flush(flush), .stall(stall1), .bubble(bubble1),
    .stall_count(cnt1), .wdog_err(wdog1), .state(state1)
  );

  hazard_stall_controller #(.REG_AW(5), .DEPTH(3), .FWD_MODE(0), .CNT_W(2), .MAX_STALL(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .src1(src1), .src2(src2),
    .use_src2(use_src2), .is_branch(is_branch), .wb_en(wb_en), .is_load(is_load),
    .dest(dest), .flush(flush), .stall(stall2), .bubble(bubble2),
    .stall_count(cnt2), .wdog_err(wdog2), .state(state2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive ID inputs, then let combinational outputs settle.
  task automatic drive(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u2, input logic br, input logic wb,
                       input logic ld, input logic [4:0] d, input logic fl);
    id_valid  = v;
    src1      = s1;
    src2      = s2;
    use_src2  = u2;
    is_branch = br;
    wb_en     = wb;
    is_load   = ld;
    dest      = d;
    flush     = fl;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;
    check_eq("rst stall0", stall0, 0);
    check_eq("rst state0", state0, 0);
    check_eq("rst cnt0", cnt0, 0);
    check_eq("rst wdog2", wdog2, 0);
    rst = 1'b0;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    idle();
    #2;
    check_eq("por stall0", stall0, 0);
    check_eq("por bubble1", bubble1, 0);
    check_eq("por state2", state2, 0);
    check_eq("por cnt1", cnt1, 0);
    check_eq("por wdog0", wdog0, 0);
    do_reset();

    // No forwarding: ALU wb r3 then consumer src1=3 -> 3 stall cycles.
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
    check_eq("A prod stall0", stall0, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("A c1 stall0", stall0, 1);
    check_eq("A c1 bubble0", bubble0, 1);
    check_eq("A c1 state0", state0, 0);
    check_eq("A c1 stall1 nonbranch", stall1, 0);
    check_eq("A c1 stall2", stall2, 1);
    step();
    check_eq("A c2 stall0", stall0, 1);
    check_eq("A c2 state0", state0, 1);
    check_eq("A c2 wdog2", wdog2, 0);
    step();
    check_eq("A c3 stall0", stall0, 1);
    check_eq("A c3 wdog2", wdog2, 1);
    step();
    check_eq("A c4 stall0", stall0, 0);
    check_eq("A c4 state0", state0, 1);
    check_eq("A c4 cnt0", cnt0, 3);
    check_eq("A c4 cnt2", cnt2, 3);
    check_eq("A c4 wdog0", wdog0, 0);
    step();
    idle();
    check_eq("A c5 state0", state0, 0);
    check_eq("A c5 bubble0", bubble0, 0);

    // Second hazard without reset: narrow counter saturates, watchdog sticky.
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    step();
    check_eq("A2 stall0", stall0, 0);
    check_eq("A2 cnt0", cnt0, 6);
    check_eq("A2 cnt2 sat", cnt2, 3);
    check_eq("A2 wdog2 sticky", wdog2, 1);
    step();

    // Reset asserted mid-stall drops stall at once; no stale hazard afterwards.
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("F pre stall0", stall0, 1);
    rst = 1'b1;
    #1;
    check_eq("F rst stall0", stall0, 0);
    check_eq("F rst bubble0", bubble0, 0);
    check_eq("F rst wdog2", wdog2, 0);
    check_eq("F rst cnt0", cnt0, 0);
    step();
    rst = 1'b0;
    #1;
    check_eq("F post stall0", stall0, 0);
    check_eq("F post state0", state0, 0);
    step();

    // Forwarding: load r5 then src2=5 with use_src2 -> 1 stall cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 5, 0);
    step();
    drive(1, 0, 5, 1, 0, 0, 0, 0, 0);
    check_eq("B c1 stall1", stall1, 1);
    step();
    check_eq("B c2 stall1", stall1, 0);
    check_eq("B c2 cnt1", cnt1, 1);
    check_eq("B c2 state1", state1, 1);

    // Same pair without use_src2 -> no stall in either mode.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 5, 0);
    step();
    drive(1, 0, 5, 0, 0, 0, 0, 0, 0);
    check_eq("B2 stall1", stall1, 0);
    check_eq("B2 stall0", stall0, 0);
    step();
    check_eq("B2 cnt1", cnt1, 0);

    // Forwarding: ALU wb r7 then branch src1=7 -> 2 stall cycles.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 7, 0);
    step();
    drive(1, 7, 0, 0, 1, 0, 0, 0, 0);
    check_eq("C c1 stall1", stall1, 1);
    step();
    check_eq("C c2 stall1", stall1, 1);
    step();
    check_eq("C c3 stall1", stall1, 0);
    check_eq("C c3 cnt1", cnt1, 2);

    // Writer of r0 never creates a hazard.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    step();
    drive(1, 0, 0, 1, 1, 0, 0, 0, 0);
    check_eq("D stall0", stall0, 0);
    check_eq("D stall1", stall1, 0);
    step();
    check_eq("D cnt0", cnt0, 0);

    // Flush in the 2nd stall cycle.
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 0, 3, 0);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("E c1 stall0", stall0, 1);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 1);
    check_eq("E c2 flush stall0", stall0, 0);
    check_eq("E c2 state0", state0, 1);
    step();
    drive(1, 3, 0, 0, 0, 0, 0, 0, 0);
    check_eq("E c3 state0", state0, 2);
    check_eq("E c3 stall0", stall0, 0);
    check_eq("E c3 cnt0", cnt0, 1);
    step();
    idle();
    check_eq("E c4 state0", state0, 0);
    check_eq("E c4 wdog0", wdog0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
HAZARD_STALL_CONTROLLER -- requirements
Module: hazard_stall_controller

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- REG_AW, 5, register address width
- DEPTH, 3, in-flight stages tracked after ID; entry 0 = EXE, 1 = MEM, 2 = WB, ...; legal range 1..8
- FWD_MODE, 1, 0 = no forwarding, 1 = forwarding present
- CNT_W, 16, stall counter width
- MAX_STALL, 8, consecutive-stall watchdog limit
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst, in, 1, asynchronous active-high reset
- id_valid, in, 1, a real instruction occupies ID
- src1, in, REG_AW, rs of the ID instruction
- src2, in, REG_AW, rt of the ID instruction
- use_src2, in, 1, src2 is read (non-immediate, or BNE/store)
- is_branch, in, 1, ID instruction is a BEZ/BNE branch
- wb_en, in, 1, ID instruction writes a register
- is_load, in, 1, ID instruction is a memory read
- dest, in, REG_AW, destination of the ID instruction
- flush, in, 1, squash all in-flight tracking
- stall, out, 1, freeze PC and IF/ID
- bubble, out, 1, insert NOP into EXE
- stall_count, out, CNT_W, total stall cycles
- wdog_err, out, 1, sticky watchdog error
- state, out, 2, FSM state for debug
REQ-003 Clock and reset SHALL be one clock clk and asynchronous, active-high reset rst.

Function
REQ-004 The block SHALL hold a DEPTH-entry tracker; each entry is {v, wb, ld, dst}.
REQ-005 The tracker SHALL shift every clock edge, independent of stall: entry[k] <= entry[k-1] for k >= 1.
REQ-006 entry[0] SHALL load {1, wb_en, is_load, dest} when id_valid & !stall & !flush; otherwise it SHALL load v = 0.
REQ-007 match[k] SHALL be: entry[k].v & entry[k].wb & (entry[k].dst != 0) & ((src1 == dst) | (use_src2 & src2 == dst)).
REQ-008 A destination of register 0 SHALL never create a hazard.
REQ-009 With FWD_MODE = 0, hz SHALL be the OR of match[k] over all k.
REQ-010 With FWD_MODE = 1, hz SHALL be (match[0] & entry[0].ld) | (is_branch & (match[0] | (DEPTH > 1 & match[1]))).
REQ-011 stall SHALL be combinational, with zero-cycle latency: stall = id_valid & hz & !flush.
REQ-012 bubble SHALL equal stall.
REQ-013 The FSM SHALL have states RUN = 0, STALL = 1, FLUSH = 2, registered, with these transitions:
- any state -> FLUSH on flush
- FLUSH -> RUN
- RUN -> STALL on stall
- STALL -> RUN on !stall
REQ-014 A flush SHALL clear every entry's v at the next edge.
REQ-015 flush SHALL take priority over a simultaneous hazard or issue.
REQ-016 stall_count SHALL increment on each edge where stall = 1 and SHALL saturate at all-ones, with no wrap.
REQ-017 An internal consecutive-stall counter SHALL increment while stall = 1 and SHALL clear when stall = 0 or on flush.
REQ-018 wdog_err SHALL set when the consecutive-stall counter reaches MAX_STALL; it SHALL stay set until rst.
REQ-019 With FWD_MODE = 0, the maximum stall per hazard SHALL be DEPTH cycles.

Reset
REQ-020 On rst, asynchronously:
- all tracker v = 0
- state = RUN
- stall_count = 0
- consecutive-stall counter = 0
- wdog_err = 0
REQ-021 With tracker v = 0, stall and bubble SHALL be 0 while rst is high.
REQ-022 rst asserted mid-stall SHALL drop stall immediately; after release, no hazard from pre-reset instructions SHALL remain.

Verification
REQ-023 FWD_MODE = 0, DEPTH = 3: issue wb to r3; next ID instruction has src1 = 3 -> stall = 1 for exactly 3 cycles; stall_count = 3; state RUN -> STALL -> RUN.
REQ-024 FWD_MODE = 1: a load to r5 followed by src2 = 5 with use_src2 = 1 -> exactly 1 stall cycle; with use_src2 = 0 -> 0 stall cycles.
REQ-025 FWD_MODE = 1: an ALU wb to r7 followed by a branch with src1 = 7 -> 2 stall cycles; a non-branch consumer -> 0 stall cycles.
REQ-026 An instruction writing r0 followed by a consumer with src1 = 0 -> no stall in either mode.
REQ-027 flush asserted in the 2nd stall cycle -> stall = 0 in that cycle; state = FLUSH next cycle, then RUN; the tracker is empty, so the re-presented consumer does not stall.
REQ-028 MAX_STALL = 2, FWD_MODE = 0, DEPTH = 3 hazard -> wdog_err rises after the 2nd consecutive stall edge and stays 1 until rst.
